// File: rtl/audio_i2s_tx_if.sv
// Output-FIFO handshake between the FM radio pipeline and the I2S transmitter.
// The transmitter is the master: it sees the FIFO heads and issues the shared pop.
interface audio_i2s_tx_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] left_audio;
    logic [DATA_WIDTH-1:0] right_audio;
    logic                  left_out_empty;
    logic                  right_out_empty;
    logic                  out_rd_en;

    modport master (
        input  left_audio,
        input  right_audio,
        input  left_out_empty,
        input  right_out_empty,
        output out_rd_en
    );

    modport slave (
        output left_audio,
        output right_audio,
        output left_out_empty,
        output right_out_empty,
        input  out_rd_en
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: drains the left/right audio FIFOs once per frame, scales and
// saturates each word to SAMPLE_BITS and serializes the pair MSB-first.
module audio_i2s_tx #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SHIFT       = 0,
    parameter int unsigned BCLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    audio_i2s_tx_if.master        fifo,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata,
    output logic                  underrun,
    output logic [15:0]           underrun_count,
    output logic                  busy
);

    localparam int unsigned W      = SAMPLE_BITS;
    localparam int unsigned SLOTS  = 2 * W;
    localparam int unsigned SLOT_W = $clog2(SLOTS);
    localparam int unsigned DIV_W  = $clog2(BCLK_DIV);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(W - 1);
    localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(SLOTS - 2);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [SLOT_W-1:0]   slot;
    logic [W-1:0]        left_hold;
    logic [W-1:0]        right_hold;
    logic [SLOTS-1:0]    shreg;
    logic                rd_en_q;

    logic                fifo_ready;
    logic                slot_edge;
    logic [SLOT_W-1:0]   slot_nxt;
    logic                fetch;
    logic [W-1:0]        left_conv;
    logic [W-1:0]        right_conv;

    // Arithmetic shift then clamp to the signed W-bit range.
    function automatic logic [W-1:0] to_sample(input logic [DATA_WIDTH-1:0] word);
        logic signed [DATA_WIDTH-1:0] sh;
        sh = $signed(word) >>> SHIFT;
        if ((&sh[DATA_WIDTH-1:W-1]) || !(|sh[DATA_WIDTH-1:W-1])) begin
            return sh[W-1:0];
        end else if (sh[DATA_WIDTH-1]) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    assign fifo_ready = !fifo.left_out_empty && !fifo.right_out_empty;
    assign left_conv  = to_sample(fifo.left_audio);
    assign right_conv = to_sample(fifo.right_audio);

    // A slot starts on the clk edge where bclk falls.
    assign slot_edge = (state != IDLE) && (div_cnt == DIV_LAST) && i2s_bclk;
    assign slot_nxt  = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
    assign fetch     = enable && ((state == IDLE) || (slot_edge && (slot_nxt == LAST_SLOT)));

    assign fifo.out_rd_en = rd_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            div_cnt        <= '0;
            slot           <= '0;
            left_hold      <= '0;
            right_hold     <= '0;
            shreg          <= '0;
            rd_en_q        <= 1'b0;
            i2s_bclk       <= 1'b0;
            i2s_lrclk      <= 1'b0;
            i2s_sdata      <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            busy           <= 1'b0;
        end else begin
            rd_en_q  <= 1'b0;
            underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= LEAD;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        slot      <= LAST_SLOT;
                        shreg     <= '0;
                        i2s_bclk  <= 1'b0;
                        i2s_lrclk <= 1'b0;
                        i2s_sdata <= 1'b0;
                    end
                end

                LEAD, RUN: begin
                    state <= RUN;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        i2s_bclk <= !i2s_bclk;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end

                    if (slot_edge) begin
                        slot <= slot_nxt;
                        if ((slot_nxt == LAST_SLOT) && !enable) begin
                            // Frame finished with run request gone: park without fetching.
                            state     <= IDLE;
                            busy      <= 1'b0;
                            div_cnt   <= '0;
                            slot      <= '0;
                            shreg     <= '0;
                            i2s_lrclk <= 1'b0;
                            i2s_sdata <= 1'b0;
                        end else begin
                            i2s_lrclk <= (slot_nxt >= LR_FIRST) && (slot_nxt <= LR_LAST);
                            if (slot_nxt == '0) begin
                                {i2s_sdata, shreg} <= {left_hold, right_hold, 1'b0};
                            end else begin
                                {i2s_sdata, shreg} <= {shreg, 1'b0};
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Fetch event at the start of slot 2W-1 (including the lead cycle).
            if (fetch) begin
                if (fifo_ready) begin
                    rd_en_q    <= 1'b1;
                    left_hold  <= left_conv;
                    right_hold <= right_conv;
                end else begin
                    left_hold  <= '0;
                    right_hold <= '0;
                    underrun   <= 1'b1;
                    if (underrun_count != 16'hFFFF) begin
                        underrun_count <= underrun_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: default instance plus a SHIFT=4 instance
// fed from a constant FIFO; frames are logged per clk and compared to an ideal waveform.
module tb_audio_i2s_tx;

    localparam int LOG_N = 8192;
    localparam int FRAME = 256;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    logic        bclk, lrclk, sdata, underrun, busy;
    logic [15:0] ucount;
    logic        bclk2, lrclk2, sdata2, underrun2, busy2;
    logic [15:0] ucount2;

    audio_i2s_tx_if #(.DATA_WIDTH(32)) fifo_a ();
    audio_i2s_tx_if #(.DATA_WIDTH(32)) fifo_b ();

    audio_i2s_tx dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo(fifo_a),
        .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .underrun(underrun), .underrun_count(ucount), .busy(busy)
    );

    audio_i2s_tx #(.SHIFT(4)) dut_shift (
        .clk(clk), .reset(reset), .enable(enable), .fifo(fifo_b),
        .i2s_bclk(bclk2), .i2s_lrclk(lrclk2), .i2s_sdata(sdata2),
        .underrun(underrun2), .underrun_count(ucount2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic bk_log [LOG_N];
    logic lr_log [LOG_N];
    logic sd_log [LOG_N];
    logic sd2_log[LOG_N];

    int          rd_q[$];
    int          un_q[$];
    logic [31:0] lq[$];
    logic [31:0] rq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_a.left_audio      = (lq.size() > 0) ? lq[0] : 32'h0;
        fifo_a.right_audio     = (rq.size() > 0) ? rq[0] : 32'h0;
        fifo_a.left_out_empty  = (lq.size() == 0);
        fifo_a.right_out_empty = (rq.size() == 0);
    endtask

    // One clk: model FIFO pop, then log outputs #1 after the edge.
    task automatic tick();
        logic pop;
        pop = fifo_a.out_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            if (lq.size() > 0) lq.delete(0);
            if (rq.size() > 0) rq.delete(0);
        end
        drive_fifo();
        if (cyc < LOG_N) begin
            bk_log[cyc]  = bclk;
            lr_log[cyc]  = lrclk;
            sd_log[cyc]  = sdata;
            sd2_log[cyc] = sdata2;
        end
        if (fifo_a.out_rd_en) rd_q.push_back(cyc);
        if (underrun) un_q.push_back(cyc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ideal waveform over one frame starting at the fetch cycle t0.
    function automatic int frame_errs(input int t0, input logic [31:0] lr_word,
                                      input logic lead_bit, input bit sel);
        int errs;
        errs = 0;
        for (int c = 0; c < FRAME; c++) begin
            int   s;
            logic eb, el, es;
            s  = c / 8 - 1;
            eb = (c % 8) >= 4;
            el = (s >= 15) && (s <= 30);
            es = (s < 0) ? lead_bit : lr_word[31 - s];
            if (sel) begin
                if (sd2_log[t0 + c] !== es) errs++;
            end else begin
                if (bk_log[t0 + c] !== eb || lr_log[t0 + c] !== el || sd_log[t0 + c] !== es) errs++;
            end
        end
        return errs;
    endfunction

    // Enable, run into slot 5, drop enable, stop at the slot 2W-1 start.
    task automatic single_frame(output int t0, output logic [5:0] lead_v, output logic [3:0] idle_v);
        rd_q.delete();
        un_q.delete();
        enable = 1'b1;
        tick();
        t0     = cyc;
        lead_v = {busy, fifo_a.out_rd_en, underrun, bclk, lrclk, sdata};
        ticks(50);
        enable = 1'b0;
        ticks(FRAME - 50);
        idle_v = {busy, bclk, lrclk, sdata};
        ticks(8);
    endtask

    int          t0;
    int          bad;
    logic [5:0]  lead_v;
    logic [3:0]  idle_v;

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        drive_fifo();
        fifo_b.left_audio      = 32'h0001_2345;
        fifo_b.right_audio     = 32'hFFFE_0000;
        fifo_b.left_out_empty  = 1'b0;
        fifo_b.right_out_empty = 1'b0;

        ticks(3);
        check("reset_outputs", 32'({bclk, lrclk, sdata, fifo_a.out_rd_en, underrun, busy, ucount}), 32'h0);
        reset = 1'b1;
        ticks(3);
        check("idle_busy", 32'(busy), 32'h0);

        // Single frame with enable dropped at slot 5.
        lq.push_back(32'h0000_1234);
        rq.push_back(32'hFFFF_8000);
        drive_fifo();
        single_frame(t0, lead_v, idle_v);
        check("b_lead", 32'(lead_v), 32'b110000);
        check("b_idle", 32'(idle_v), 32'h0);
        check("b_frame", 32'(frame_errs(t0, {16'h1234, 16'h8000}, 1'b0, 1'b0)), 32'h0);
        check("b_shift_frame", 32'(frame_errs(t0, {16'h1234, 16'hE000}, 1'b0, 1'b1)), 32'h0);
        check("b_rd_pulses", 32'(rd_q.size()), 32'd1);
        check("b_rd_cycle", 32'((rd_q.size() > 0) ? rd_q[0] - t0 : -1), 32'd0);
        check("b_underruns", 32'(un_q.size()), 32'd0);

        // Saturation on the default instance.
        lq.push_back(32'h0001_2345);
        rq.push_back(32'hFFFE_0000);
        drive_fifo();
        ticks(5);
        single_frame(t0, lead_v, idle_v);
        check("c_lead", 32'(lead_v), 32'b110000);
        check("c_frame", 32'(frame_errs(t0, {16'h7FFF, 16'h8000}, 1'b0, 1'b0)), 32'h0);
        check("c_shift_frame", 32'(frame_errs(t0, {16'h1234, 16'hE000}, 1'b0, 1'b1)), 32'h0);

        // Underrun with both FIFOs empty.
        ticks(5);
        single_frame(t0, lead_v, idle_v);
        check("d_lead", 32'(lead_v), 32'b101000);
        check("d_count", 32'(ucount), 32'd1);
        check("d_un_pulses", 32'(un_q.size()), 32'd1);
        check("d_rd_pulses", 32'(rd_q.size()), 32'd0);
        check("d_frame", 32'(frame_errs(t0, 32'h0, 1'b0, 1'b0)), 32'h0);

        // Underrun with only the right FIFO empty; left must not be popped.
        lq.push_back(32'h0000_1111);
        drive_fifo();
        ticks(5);
        single_frame(t0, lead_v, idle_v);
        check("e_lead", 32'(lead_v), 32'b101000);
        check("e_count", 32'(ucount), 32'd2);
        check("e_left_kept", 32'(lq.size()), 32'd1);
        check("e_frame", 32'(frame_errs(t0, 32'h0, 1'b0, 1'b0)), 32'h0);
        lq.delete();
        drive_fifo();

        // Streaming three pairs, fourth fetch underruns.
        lq.push_back(32'h0000_0A5A); rq.push_back(32'hFFFF_F0F0);
        lq.push_back(32'h0000_7FFF); rq.push_back(32'hFFFF_8000);
        lq.push_back(32'h0000_0001); rq.push_back(32'hFFFF_FFFF);
        drive_fifo();
        ticks(5);
        rd_q.delete();
        un_q.delete();
        enable = 1'b1;
        tick();
        t0 = cyc;
        ticks(3 * FRAME + 50);
        enable = 1'b0;
        ticks(FRAME - 50);
        check("f_idle", 32'({busy, bclk, lrclk, sdata}), 32'h0);
        ticks(8);
        check("f_rd_pulses", 32'(rd_q.size()), 32'd3);
        if (rd_q.size() == 3) begin
            check("f_rd_first", 32'(rd_q[0] - t0), 32'd0);
            check("f_rd_gap1", 32'(rd_q[1] - rd_q[0]), 32'd256);
            check("f_rd_gap2", 32'(rd_q[2] - rd_q[1]), 32'd256);
        end
        check("f_un_cycle", 32'((un_q.size() == 1) ? un_q[0] - t0 : -1), 32'd768);
        check("f_count", 32'(ucount), 32'd3);
        check("f_frame0", 32'(frame_errs(t0,             {16'h0A5A, 16'hF0F0}, 1'b0, 1'b0)), 32'h0);
        check("f_frame1", 32'(frame_errs(t0 + FRAME,     {16'h7FFF, 16'h8000}, 1'b0, 1'b0)), 32'h0);
        check("f_frame2", 32'(frame_errs(t0 + 2 * FRAME, {16'h0001, 16'hFFFF}, 1'b0, 1'b0)), 32'h0);
        check("f_frame3", 32'(frame_errs(t0 + 3 * FRAME, 32'h0,                1'b1, 1'b0)), 32'h0);

        // Asynchronous reset in the middle of a frame.
        lq.push_back(32'h0000_2222);
        rq.push_back(32'h0000_3333);
        drive_fifo();
        enable = 1'b1;
        ticks(40);
        check("g_running", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("g_reset_outputs",
              32'({bclk, lrclk, sdata, fifo_a.out_rd_en, underrun, busy, ucount}), 32'h0);
        enable = 1'b0;
        tick();
        reset = 1'b1;
        lq.push_back(32'h0000_4444);
        rq.push_back(32'h0000_5555);
        drive_fifo();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bclk || fifo_a.out_rd_en || busy) bad++;
        end
        check("g_quiet_after_reset", 32'(bad), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
